// File: rtl/register_if.sv
// Register-file access bundle: one write port and two independent read ports.
interface register_if #(
    parameter int XLEN = 64
);
    logic            we;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    modport master (output we, rs1, rs2, rd, wd, input rd1, rd2);
    modport slave  (input we, rs1, rs2, rd, wd, output rd1, rd2);
endinterface

// File: rtl/register.sv
// 32-entry integer register file: x0 hardwired to zero, one synchronous write port,
// two combinational read ports, asynchronous clear.
module register #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic      clk,
    input  logic      rst,
    register_if.slave bus
);

    // x0 has no storage; it is synthesised as a constant zero on the read side.
    logic [XLEN-1:0] regs_r [1:NREGS-1];
    logic [XLEN-1:0] rd1_s;
    logic [XLEN-1:0] rd2_s;
    logic            wr_en_s;

    assign wr_en_s = bus.we && (bus.rd != 5'd0);

    // Storage update: asynchronous clear, otherwise single-entry write on rising clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[bus.rd] <= bus.wd;
        end
    end

    // Read ports: no bypass, so a pending write is visible only after the edge.
    always_comb begin
        rd1_s = {XLEN{1'b0}};
        rd2_s = {XLEN{1'b0}};
        if (bus.rs1 != 5'd0) begin
            rd1_s = regs_r[bus.rs1];
        end else begin
            rd1_s = {XLEN{1'b0}};
        end
        if (bus.rs2 != 5'd0) begin
            rd2_s = regs_r[bus.rs2];
        end else begin
            rd2_s = {XLEN{1'b0}};
        end
    end

    assign bus.rd1 = rd1_s;
    assign bus.rd2 = rd2_s;

endmodule

// File: tb/tb_register.sv
// Randomised self-checking bench for the register file against an array model.
module tb_register;
    localparam int XLEN = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [XLEN-1:0] model [32];

    always #5 clk = ~clk;

    register_if #(.XLEN(XLEN)) bus ();
    register #(.XLEN(XLEN), .NREGS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic check_eq(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    // One clock: drive at negedge, check old contents before the edge, new contents after.
    task automatic cycle(input logic we, input logic [4:0] rd, input logic [XLEN-1:0] wd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input string tag);
        @(negedge clk);
        bus.we = we; bus.rd = rd; bus.wd = wd; bus.rs1 = rs1; bus.rs2 = rs2;
        #1;
        check_eq({tag, "_pre1"}, bus.rd1, model[rs1]);
        check_eq({tag, "_pre2"}, bus.rd2, model[rs2]);
        @(posedge clk);
        if (we && rd != 5'd0) model[rd] = wd;
        #1;
        check_eq({tag, "_post1"}, bus.rd1, model[rs1]);
        check_eq({tag, "_post2"}, bus.rd2, model[rs2]);
    endtask

    task automatic set_reads(input logic [4:0] rs1, input logic [4:0] rs2);
        bus.rs1 = rs1; bus.rs2 = rs2;
        #1;
    endtask

    initial begin
        logic [XLEN-1:0] ones;
        logic [4:0] r_rd, r_rs1, r_rs2;
        logic [XLEN-1:0] r_wd;
        ones = '1;
        clear_model();
        bus.we = 1'b1; bus.rd = 5'd7; bus.wd = 64'hDEAD; bus.rs1 = 5'd0; bus.rs2 = 5'd0;

        // Reset held across edges with a write pending: everything reads zero.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i += 7) begin
            set_reads(i[4:0], 5'd31 - i[4:0]);
            check_eq("reset_rd1", bus.rd1, 64'd0);
            check_eq("reset_rd2", bus.rd2, 64'd0);
        end
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b0;

        // Basic write/read, second register, x0 protection.
        cycle(1'b1, 5'd1, 64'd42, 5'd1, 5'd0, "w1");
        check_eq("req025_rd1", bus.rd1, 64'd42);
        check_eq("req025_rd2", bus.rd2, 64'd0);
        cycle(1'b1, 5'd2, 64'd100, 5'd2, 5'd1, "w2");
        check_eq("req026_rd1", bus.rd1, 64'd100);
        check_eq("req026_rd2", bus.rd2, 64'd42);
        cycle(1'b1, 5'd0, 64'd999, 5'd0, 5'd1, "w0");
        check_eq("req027_rd1", bus.rd1, 64'd0);
        check_eq("req027_rd2", bus.rd2, 64'd42);

        // Disabled write then enabled write to the top index.
        cycle(1'b0, 5'd31, ones, 5'd31, 5'd31, "x31_off");
        check_eq("req028_off", bus.rd1, 64'd0);
        cycle(1'b1, 5'd31, ones, 5'd31, 5'd2, "x31_on");
        check_eq("req028_on", bus.rd1, 64'hFFFF_FFFF_FFFF_FFFF);

        // No bypass on x5.
        cycle(1'b1, 5'd5, 64'd3, 5'd5, 5'd5, "x5_a");
        @(negedge clk);
        bus.we = 1'b1; bus.rd = 5'd5; bus.wd = 64'd7; bus.rs1 = 5'd5; bus.rs2 = 5'd1;
        #1 check_eq("req029_before", bus.rd1, 64'd3);
        @(posedge clk);
        model[5] = 64'd7;
        #1 check_eq("req029_after", bus.rd1, 64'd7);

        // Async reset between edges clears immediately.
        @(negedge clk);
        bus.we = 1'b0; bus.rs1 = 5'd1; bus.rs2 = 5'd2;
        #1 check_eq("req030_pre1", bus.rd1, 64'd42);
        rst = 1'b1;
        #1;
        check_eq("req030_rd1", bus.rd1, 64'd0);
        check_eq("req030_rd2", bus.rd2, 64'd0);
        clear_model();
        #1 rst = 1'b0;

        // Reset coinciding with a write: reset wins.
        @(negedge clk);
        bus.we = 1'b1; bus.rd = 5'd3; bus.wd = 64'h1234; bus.rs1 = 5'd3; bus.rs2 = 5'd3;
        rst = 1'b1;
        @(posedge clk);
        #1 check_eq("req024_during", bus.rd1, 64'd0);
        @(negedge clk);
        bus.we = 1'b0;
        rst = 1'b0;
        #1 check_eq("req024_after", bus.rd2, 64'd0);

        // First write after release takes effect on the first edge.
        cycle(1'b1, 5'd3, 64'hABCD, 5'd3, 5'd0, "post_rst");
        check_eq("req023", bus.rd1, 64'hABCD);

        // Randomised traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                r_rs1 = 5'($urandom_range(0, 31));
                set_reads(r_rs1, 5'($urandom_range(0, 31)));
                check_eq("rnd_rst1", bus.rd1, 64'd0);
                check_eq("rnd_rst2", bus.rd2, 64'd0);
                clear_model();
                #1 rst = 1'b0;
            end
            r_rd  = 5'($urandom_range(0, 31));
            r_wd  = {$urandom, $urandom};
            r_rs1 = ($urandom_range(0, 3) == 0) ? r_rd : 5'($urandom_range(0, 31));
            r_rs2 = ($urandom_range(0, 3) == 0) ? r_rs1 : 5'($urandom_range(0, 31));
            cycle(($urandom_range(0, 3) != 0), r_rd, r_wd, r_rs1, r_rs2, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 Parameter: XLEN, default 64, data width of each register and of the wd/rd1/rd2 ports.
REQ-002 Parameter: NREGS, fixed 32, register count; the 5-bit index ports address x0..x31.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset is asynchronous and active-high.
REQ-005 we  input  1  write enable, sampled on rising clk.
REQ-006 rs1  input  5  read port 1 register index.
REQ-007 rs2  input  5  read port 2 register index.
REQ-008 rd  input  5  write register index.
REQ-009 wd  input  XLEN  write data.
REQ-010 rd1  output  XLEN  read data for rs1.
REQ-011 rd2  output  XLEN  read data for rs2.

Function
REQ-012 The block SHALL hold 32 registers x0..x31 of XLEN bits each.
REQ-013 On a rising clk edge with rst low, we=1 and rd!=0, the block SHALL load wd into register rd.
REQ-014 When we=0, the block SHALL leave all registers unchanged.
REQ-015 When rd=0, writes SHALL be discarded, and x0 SHALL read as all-zero at all times.
REQ-016 Reads SHALL be combinational with zero-cycle latency: rd1 = x[rs1], rd2 = x[rs2], and each SHALL update whenever its index or the addressed register changes.
REQ-017 Both read ports SHALL operate independently; rs1=rs2 SHALL return the same value on both ports.
REQ-018 There SHALL be no write-to-read bypass: in the cycle a write to rd is pending, a read of rd SHALL return the old value; the new value SHALL appear immediately after the rising edge.
REQ-019 Only one register SHALL be written per cycle, with no side effects on other registers.
REQ-020 The write data SHALL be stored full-width, with no truncation or sign handling.

Reset
REQ-021 While rst is high, all 32 registers SHALL be cleared to 0 immediately, without waiting for a clock edge.
REQ-022 While rst is high, writes SHALL be ignored, and rd1/rd2 SHALL read 0 for every index.
REQ-023 Following rst deassertion, the first write SHALL take effect on the first rising clk edge at which the REQ-013 conditions hold.
REQ-024 If rst asserts in the same cycle as a write, reset SHALL win and the register SHALL read 0.

Verification
REQ-025 Basic write/read: we=1, rd=1, wd=42, one clock; then we=0, rs1=1, rs2=0 -> rd1=42, rd2=0.
REQ-026 Second register: we=1, rd=2, wd=100, one clock; then rs1=2, rs2=1 -> rd1=100, rd2=42 (x1 retained).
REQ-027 x0 protection: we=1, rd=0, wd=999, one clock; then rs1=0, rs2=1 -> rd1=0, rd2=42.
REQ-028 Disabled write and boundary index: we=0, rd=31, wd=0xFFFF_FFFF_FFFF_FFFF, one clock -> x31 reads 0; then we=1, same rd/wd -> rs1=31 reads all-ones.
REQ-029 No bypass: hold rs1=5 while we=1, rd=5, wd=7 -> rd1 shows the old value before the edge and 7 after it.
REQ-030 Async reset mid-operation: with x1=42 and x2=100, pulse rst between clock edges -> rd1/rd2 for indices 1 and 2 read 0 immediately, before the next clk edge.
